sram_2rw_bytemask_ctrl: RTL and testbench



---
 rtl/sram_2rw_bytemask_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_2rw_bytemask_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_2rw_bytemask_ctrl.sv
// Dual-port read/write SRAM model with per-byte write masks and a pipelined read path.
// Includes a post-reset clear engine and a same-address write-write collision flag.
module sram_2rw_bytemask_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 7,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int WMASK_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dout0_valid,
    input  logic                   csb1,
    input  logic                   web1,
    input  logic [WMASK_WIDTH-1:0] wmask1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0]  din1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_valid,
    output logic                   collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if ((DATA_WIDTH % 8) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_bad_param
        $error("sram_2rw_bytemask_ctrl: DATA_WIDTH must be a multiple of 8 and READ_LATENCY 1 or 2");
    end

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        IDLE_WAIT = 2'd1,
        READY     = 2'd2
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE_WAIT;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic                    clr_we;
    logic                    we0, we1, rd0, rd1;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   src0, src1;
    logic                    go0, go1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_STATE;
            clear_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clear_addr <= clear_addr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:     if (&clear_addr) state_nxt = READY;
            IDLE_WAIT: state_nxt = READY;
            READY:     state_nxt = READY;
            default:   state_nxt = RST_STATE;
        endcase
    end

    // ready drops combinationally with rst so no access slips through the reset edge
    always_comb begin
        ready  = (state == READY) && !rst;
        clr_we = (state == CLEAR) && !rst;
    end

    assign we0 = ready && !csb0 && !web0;
    assign we1 = ready && !csb1 && !web1;
    assign rd0 = ready && !csb0 && web0;
    assign rd1 = ready && !csb1 && web1;

    // Port 0 byte writes are issued last so they override port 1 on overlapping bytes
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clear_addr] <= '0;
        end else begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (we1 && wmask1[i]) mem[addr1][8*i +: 8] <= din1[8*i +: 8];
                if (we0 && wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rdat0_p0, rdat1_p0;
        logic                  vld0_p0, vld1_p0;

        // p0: array sampled read-first, advances every cycle
        always_ff @(posedge clk) begin
            rdat0_p0 <= mem[addr0];
            rdat1_p0 <= mem[addr1];
            if (rst) begin
                vld0_p0 <= 1'b0;
                vld1_p0 <= 1'b0;
            end else begin
                vld0_p0 <= rd0;
                vld1_p0 <= rd1;
            end
        end

        assign src0 = rdat0_p0;
        assign src1 = rdat1_p0;
        assign go0  = vld0_p0;
        assign go1  = vld1_p0;
    end else begin : g_lat1
        assign src0 = mem[addr0];
        assign src1 = mem[addr1];
        assign go0  = rd0;
        assign go1  = rd1;
    end

    // output stage: dout only loads on a valid, so it holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            dout0       <= '0;
            dout1       <= '0;
            dout0_valid <= 1'b0;
            dout1_valid <= 1'b0;
            collision   <= 1'b0;
        end else begin
            dout0_valid <= go0;
            dout1_valid <= go1;
            if (go0) dout0 <= src0;
            if (go1) dout1 <= src1;
            collision <= we0 && we1 && (addr0 == addr1);
        end
    end

endmodule

// File: tb/tb_sram_2rw_bytemask_ctrl.sv
// Directed bench for sram_2rw_bytemask_ctrl: a latency-1 and a latency-2 instance
// share the same stimulus; each scenario task checks its outputs inline.
module tb_sram_2rw_bytemask_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          csb0, web0, csb1, web1;
    logic [MW-1:0] wmask0, wmask1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;

    logic          ready, dout0_valid, dout1_valid, collision;
    logic [DW-1:0] dout0, dout1;
    logic          ready_l2, dout0_valid_l2, dout1_valid_l2, collision_l2;
    logic [DW-1:0] dout0_l2, dout1_l2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sram_2rw_bytemask_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .dout0_valid(dout0_valid),
        .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1),
        .dout1(dout1), .dout1_valid(dout1_valid),
        .collision(collision)
    );

    sram_2rw_bytemask_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
        .clk(clk), .rst(rst), .ready(ready_l2),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_l2), .dout0_valid(dout0_valid_l2),
        .csb1(csb1), .web1(web1), .wmask1(wmask1), .addr1(addr1), .din1(din1),
        .dout1(dout1_l2), .dout1_valid(dout1_valid_l2),
        .collision(collision_l2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        tick();
        csb0 = 1'b1; web0 = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        csb0 = 1'b0; web0 = 1'b0; din0 = '1; wmask0 = '1; addr0 = '0;
        csb1 = 1'b1; web1 = 1'b1; din1 = '0; wmask1 = '0; addr1 = '0;
        tick();
        addr0 = 4'd1;
        tick();
        total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (dout0 !== 32'h0 || dout0_valid !== 1'b0) $display("FAIL reset_dout0: got %h/%b want 0/0", dout0, dout0_valid); else pass_cnt++;
        total_cnt++; if (collision !== 1'b0) $display("FAIL reset_collision: got %b want 0", collision); else pass_cnt++;
        total_cnt++; if (dout1_l2 !== 32'h0 || dout1_valid_l2 !== 1'b0) $display("FAIL reset_dout1_l2: got %h/%b want 0/0", dout1_l2, dout1_valid_l2); else pass_cnt++;
        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
            addr0 = addr0 + 1'b1;
        end
        csb0 = 1'b1; web0 = 1'b1;
        total_cnt++; if (n != 16) $display("FAIL clear_ready_latency: got %0d cycles want 16", n); else pass_cnt++;
        total_cnt++; if (ready_l2 !== 1'b1) $display("FAIL clear_ready_l2: got %b want 1", ready_l2); else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(a);
            tick();
            total_cnt++;
            if (dout0 !== 32'h0 || dout0_valid !== 1'b1)
                $display("FAIL clear_read_%0d: got %h/%b want 00000000/1", a, dout0, dout0_valid);
            else pass_cnt++;
        end
        csb0 = 1'b1;
        tick();
    endtask

    task automatic test_bytemask();
        wr0(4'd3, 32'hDEADBEEF, 4'b1111);
        wr0(4'd3, 32'h00001122, 4'b0011);
        total_cnt++; if (dout1_valid !== 1'b0) $display("FAIL bytemask_pre_valid: got %b want 0", dout1_valid); else pass_cnt++;
        csb1 = 1'b0; web1 = 1'b1; addr1 = 4'd3;
        tick();
        csb1 = 1'b1;
        total_cnt++; if (dout1_valid !== 1'b1 || dout1 !== 32'hDEAD1122) $display("FAIL bytemask_read: got %h/%b want DEAD1122/1", dout1, dout1_valid); else pass_cnt++;
        tick();
        total_cnt++; if (dout1_valid !== 1'b0 || dout1 !== 32'hDEAD1122) $display("FAIL bytemask_hold: got %h/%b want DEAD1122/0", dout1, dout1_valid); else pass_cnt++;
        wr0(4'd4, 32'hCAFEF00D, 4'b0000);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd4;
        tick();
        csb0 = 1'b1;
        total_cnt++; if (dout0 !== 32'h0) $display("FAIL bytemask_zero_mask: got %h want 00000000", dout0); else pass_cnt++;
    endtask

    task automatic test_collision();
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 32'hAAAAAAAA; wmask0 = 4'b1100;
        csb1 = 1'b0; web1 = 1'b0; addr1 = 4'd5; din1 = 32'h55555555; wmask1 = 4'b1111;
        tick();
        csb0 = 1'b1; csb1 = 1'b1; web0 = 1'b1; web1 = 1'b1;
        total_cnt++; if (collision !== 1'b1 || collision_l2 !== 1'b1) $display("FAIL collision_pulse: got %b/%b want 1/1", collision, collision_l2); else pass_cnt++;
        tick();
        total_cnt++; if (collision !== 1'b0) $display("FAIL collision_one_cycle: got %b want 0", collision); else pass_cnt++;
        csb0 = 1'b0; addr0 = 4'd5;
        tick();
        csb0 = 1'b1;
        total_cnt++; if (dout0 !== 32'hAAAA5555) $display("FAIL collision_data: got %h want AAAA5555", dout0); else pass_cnt++;
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd8; din0 = 32'h11111111; wmask0 = 4'b1111;
        csb1 = 1'b0; web1 = 1'b0; addr1 = 4'd9; din1 = 32'h22222222; wmask1 = 4'b1111;
        tick();
        csb0 = 1'b1; csb1 = 1'b1; web0 = 1'b1; web1 = 1'b1;
        total_cnt++; if (collision !== 1'b0) $display("FAIL collision_diff_addr: got %b want 0", collision); else pass_cnt++;
        csb1 = 1'b0; addr1 = 4'd9;
        tick();
        csb1 = 1'b1;
        total_cnt++; if (dout1 !== 32'h22222222) $display("FAIL dual_write_p1: got %h want 22222222", dout1); else pass_cnt++;
    endtask

    task automatic test_read_during_write();
        wr0(4'd7, 32'h00000001, 4'b1111);
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd7; din0 = 32'h00000002; wmask0 = 4'b1111;
        csb1 = 1'b0; web1 = 1'b1; addr1 = 4'd7;
        tick();
        csb0 = 1'b1; web0 = 1'b1;
        total_cnt++; if (dout1 !== 32'h00000001 || dout1_valid !== 1'b1) $display("FAIL rdw_old: got %h/%b want 00000001/1", dout1, dout1_valid); else pass_cnt++;
        tick();
        csb1 = 1'b1;
        total_cnt++; if (dout1 !== 32'h00000002 || dout1_valid !== 1'b1) $display("FAIL rdw_new: got %h/%b want 00000002/1", dout1, dout1_valid); else pass_cnt++;
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd7;
        csb1 = 1'b0; web1 = 1'b1; addr1 = 4'd7;
        tick();
        csb0 = 1'b1; csb1 = 1'b1;
        total_cnt++; if (dout0 !== 32'h00000002 || dout1 !== 32'h00000002) $display("FAIL both_read: got %h/%h want 00000002/00000002", dout0, dout1); else pass_cnt++;
    endtask

    task automatic test_pipelined();
        wr0(4'd0, 32'h000000A0, 4'b1111);
        wr0(4'd1, 32'h000000A1, 4'b1111);
        wr0(4'd2, 32'h000000A2, 4'b1111);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd0;
        tick();
        total_cnt++; if (dout0_valid_l2 !== 1'b0) $display("FAIL pipe_early_valid: got %b want 0", dout0_valid_l2); else pass_cnt++;
        total_cnt++; if (dout0 !== 32'hA0 || dout0_valid !== 1'b1) $display("FAIL pipe_l1_first: got %h/%b want 000000a0/1", dout0, dout0_valid); else pass_cnt++;
        addr0 = 4'd1;
        tick();
        total_cnt++; if (dout0_valid_l2 !== 1'b1 || dout0_l2 !== 32'hA0) $display("FAIL pipe_0: got %h/%b want 000000a0/1", dout0_l2, dout0_valid_l2); else pass_cnt++;
        addr0 = 4'd2;
        tick();
        csb0 = 1'b1;
        total_cnt++; if (dout0_valid_l2 !== 1'b1 || dout0_l2 !== 32'hA1) $display("FAIL pipe_1: got %h/%b want 000000a1/1", dout0_l2, dout0_valid_l2); else pass_cnt++;
        tick();
        total_cnt++; if (dout0_valid_l2 !== 1'b1 || dout0_l2 !== 32'hA2) $display("FAIL pipe_2: got %h/%b want 000000a2/1", dout0_l2, dout0_valid_l2); else pass_cnt++;
        tick();
        total_cnt++; if (dout0_valid_l2 !== 1'b0 || dout0_l2 !== 32'hA2) $display("FAIL pipe_end: got %h/%b want 000000a2/0", dout0_l2, dout0_valid_l2); else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        wr0(4'd12, 32'h12345678, 4'b1111);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd12;
        tick();
        csb0 = 1'b1;
        total_cnt++; if (dout0 !== 32'h12345678) $display("FAIL fill_12: got %h want 12345678", dout0); else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++; if (dout0_valid_l2 !== 1'b0 || dout0_l2 !== 32'h0) $display("FAIL flush_inflight: got %h/%b want 0/0", dout0_l2, dout0_valid_l2); else pass_cnt++;
        total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else pass_cnt++;
        rst = 1'b0;
        repeat (8) tick();
        total_cnt++; if (ready !== 1'b0) $display("FAIL mid_clear_ready: got %b want 0", ready); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total_cnt++; if (n != 16) $display("FAIL restart_ready_latency: got %0d cycles want 16", n); else pass_cnt++;
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd12;
        tick();
        csb0 = 1'b1;
        total_cnt++; if (dout0 !== 32'h0 || dout0_valid !== 1'b1) $display("FAIL cleared_12: got %h/%b want 00000000/1", dout0, dout0_valid); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bytemask();
        test_collision();
        test_read_during_write();
        test_pipelined();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
